// File: rtl/imm_check_monitor.sv
// Multi-channel on-chip checker for the guarded rule "if (a>GUARD_TH || b>GUARD_TH) then c<=LIMIT".
// Supports assert/assume/cover modes, saturating counters, a sticky fail mask and first-failure capture.
module imm_check_monitor #(
  parameter int NUM_CH       = 2,
  parameter int WIDTH        = 4,
  parameter int GUARD_TH     = 5,
  parameter int LIMIT        = 9,
  parameter int CNT_W        = 16,
  parameter int COVER_TARGET = 4,
  parameter int STOP_ON_FAIL = 1,
  localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*WIDTH-1:0] a_flat,
  input  logic [NUM_CH*WIDTH-1:0] b_flat,
  input  logic [NUM_CH*WIDTH-1:0] c_flat,
  output logic [1:0]              state,
  output logic [CNT_W-1:0]        eval_cnt,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic [NUM_CH-1:0]       fail_mask,
  output logic                    first_fail_vld,
  output logic [CHW-1:0]          first_fail_ch,
  output logic [CNT_W-1:0]        first_fail_cyc,
  output logic                    err
);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam logic [WIDTH-1:0] GTH = WIDTH'(GUARD_TH);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_HALTED = 2'd2, S_DONE = 2'd3} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        mode_q_reg;
  logic [CNT_W-1:0]  cycle_cnt_reg, eval_cnt_reg, pass_cnt_reg, fail_cnt_reg, first_fail_cyc_reg;
  logic [NUM_CH-1:0] fail_mask_reg;
  logic              first_fail_vld_reg, err_reg;
  logic [CHW-1:0]    first_fail_ch_reg;

  logic [NUM_CH-1:0] g, p, f;
  logic [PW-1:0]     pop_g, pop_p, pop_f;
  logic [CHW-1:0]    low_ch;
  logic [CNT_W-1:0]  pass_next;
  logic              is_cover, is_assume, is_assert, eval_en, any_fail;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] a_i, b_i, c_i;
    assign a_i   = a_flat[gi*WIDTH +: WIDTH];
    assign b_i   = b_flat[gi*WIDTH +: WIDTH];
    assign c_i   = c_flat[gi*WIDTH +: WIDTH];
    assign g[gi] = (a_i > GTH) | (b_i > GTH);
    assign p[gi] = g[gi] & (c_i <= LIM);
    assign f[gi] = g[gi] & ~(c_i <= LIM);
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x, input logic [PW-1:0] y);
    logic [CNT_W:0] s;
    s = {1'b0, x} + (CNT_W+1)'(y);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    pop_g  = '0;
    pop_p  = '0;
    pop_f  = '0;
    low_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop_g = pop_g + PW'(g[i]);
      pop_p = pop_p + PW'(p[i]);
      pop_f = pop_f + PW'(f[i]);
    end
    // Scan downward so the lowest failing channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (f[i]) low_ch = CHW'(i);
    end
  end

  assign is_cover  = (mode_q_reg == 2'd2);
  assign is_assume = (mode_q_reg == 2'd1);
  assign is_assert = !is_cover && !is_assume;
  assign eval_en   = (state_reg == S_ARMED) && en;
  assign any_fail  = |f;
  assign pass_next = sat_add(pass_cnt_reg, pop_p);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (en) state_next = S_ARMED;
      S_ARMED: begin
        if (!en)
          state_next = S_IDLE;
        else if (is_assert && any_fail && (STOP_ON_FAIL != 0))
          state_next = S_HALTED;
        else if (is_cover && (32'(pass_next) >= 32'(COVER_TARGET)))
          state_next = S_DONE;
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_reg          <= S_IDLE;
      mode_q_reg         <= 2'd0;
      cycle_cnt_reg      <= '0;
      eval_cnt_reg       <= '0;
      pass_cnt_reg       <= '0;
      fail_cnt_reg       <= '0;
      fail_mask_reg      <= '0;
      first_fail_vld_reg <= 1'b0;
      first_fail_ch_reg  <= '0;
      first_fail_cyc_reg <= '0;
      err_reg            <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= 1'b0;
      if (state_reg == S_IDLE && en) mode_q_reg <= mode;
      if (eval_en) begin
        cycle_cnt_reg <= sat_add(cycle_cnt_reg, PW'(1));
        eval_cnt_reg  <= sat_add(eval_cnt_reg, pop_g);
        pass_cnt_reg  <= pass_next;
        if (!is_cover) begin
          fail_cnt_reg  <= sat_add(fail_cnt_reg, pop_f);
          fail_mask_reg <= fail_mask_reg | f;
          err_reg       <= is_assert && any_fail;
          if (any_fail && !first_fail_vld_reg) begin
            first_fail_vld_reg <= 1'b1;
            first_fail_ch_reg  <= low_ch;
            first_fail_cyc_reg <= cycle_cnt_reg;
          end
        end
      end
    end
  end

  assign state          = state_reg;
  assign eval_cnt       = eval_cnt_reg;
  assign pass_cnt       = pass_cnt_reg;
  assign fail_cnt       = fail_cnt_reg;
  assign fail_mask      = fail_mask_reg;
  assign first_fail_vld = first_fail_vld_reg;
  assign first_fail_ch  = first_fail_ch_reg;
  assign first_fail_cyc = first_fail_cyc_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_imm_check_monitor.sv
// Bench for imm_check_monitor: directed scenarios plus random traffic against an integer-level model.
module tb_imm_check_monitor;
  localparam int MAXV = 65535;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] a_flat = '0, b_flat = '0, c_flat = '0;

  logic [1:0]  state, s_state;
  logic [15:0] eval_cnt, pass_cnt, fail_cnt, first_fail_cyc;
  logic [2:0]  s_eval, s_pass, s_fail, s_cyc;
  logic [1:0]  fail_mask, s_mask;
  logic        first_fail_vld, err, s_vld, s_err;
  logic [0:0]  first_fail_ch, s_ch;

  int checks = 0, errors = 0;

  // Reference model state (plain integers)
  int m_state, m_mode, m_cyc, m_eval, m_pass, m_fail, m_mask, m_ffv, m_ffch, m_ffcyc, m_err;

  always #5 clk = ~clk;

  imm_check_monitor dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
    .state(state), .eval_cnt(eval_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_mask(fail_mask), .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch),
    .first_fail_cyc(first_fail_cyc), .err(err)
  );

  imm_check_monitor #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
    .state(s_state), .eval_cnt(s_eval), .pass_cnt(s_pass), .fail_cnt(s_fail),
    .fail_mask(s_mask), .first_fail_vld(s_vld), .first_fail_ch(s_ch),
    .first_fail_cyc(s_cyc), .err(s_err)
  );

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic model_clear();
    m_state = 0; m_mode = 0; m_cyc = 0; m_eval = 0; m_pass = 0; m_fail = 0;
    m_mask = 0; m_ffv = 0; m_ffch = 0; m_ffcyc = 0; m_err = 0;
  endtask

  task automatic model_step();
    int ng, np, nf, fm, lowest, av, bv, cv;
    if (rst || clr) begin
      model_clear();
      return;
    end
    m_err = 0;
    if (m_state == 0) begin
      if (en) begin m_state = 1; m_mode = int'(mode); end
    end else if (m_state == 1) begin
      if (!en) m_state = 0;
      else begin
        ng = 0; np = 0; nf = 0; fm = 0; lowest = -1;
        for (int ch = 0; ch < 2; ch++) begin
          av = int'((a_flat >> (4*ch)) & 8'hF);
          bv = int'((b_flat >> (4*ch)) & 8'hF);
          cv = int'((c_flat >> (4*ch)) & 8'hF);
          if (av > 5 || bv > 5) begin
            ng++;
            if (cv <= 9) np++;
            else begin
              nf++; fm |= (1 << ch);
              if (lowest < 0) lowest = ch;
            end
          end
        end
        m_eval = imin(m_eval + ng, MAXV);
        m_pass = imin(m_pass + np, MAXV);
        if (m_mode == 2) begin
          if (m_pass >= 4) m_state = 3;
        end else begin
          m_fail = imin(m_fail + nf, MAXV);
          m_mask |= fm;
          if (nf > 0 && m_ffv == 0) begin m_ffv = 1; m_ffch = lowest; m_ffcyc = m_cyc; end
          if (m_mode != 1 && nf > 0) begin m_err = 1; m_state = 2; end
        end
        m_cyc = imin(m_cyc + 1, MAXV);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    $display("t=%0t rst=%b clr=%b en=%b mode=%0d a=%h b=%h c=%h | st=%0d ev=%0d ps=%0d fl=%0d mask=%b ffv=%b ffch=%0d ffcyc=%0d err=%b",
             $time, rst, clr, en, mode, a_flat, b_flat, c_flat, state, eval_cnt, pass_cnt, fail_cnt,
             fail_mask, first_fail_vld, first_fail_ch, first_fail_cyc, err);
  endtask

  task automatic set_ops(input int a0, input int b0, input int c0, input int a1, input int b1, input int c1);
    a_flat = {4'(a1), 4'(a0)};
    b_flat = {4'(b1), 4'(b0)};
    c_flat = {4'(c1), 4'(c0)};
  endtask

  task automatic test_reset();
    rst = 1; clr = 0; en = 0; mode = 0; set_ops(0, 0, 0, 0, 0, 0);
    tick(); tick();
    checks++;
    if ({state, eval_cnt, pass_cnt, fail_cnt, fail_mask, first_fail_vld, first_fail_ch, first_fail_cyc, err} !== '0) begin
      errors++;
      $display("FAIL reset: state=%0d ev=%0d ps=%0d fl=%0d mask=%b ffv=%b err=%b, required all 0",
               state, eval_cnt, pass_cnt, fail_cnt, fail_mask, first_fail_vld, err);
    end
    rst = 0;
  endtask

  task automatic test_assert_pass();
    en = 1; mode = 2'd0; set_ops(6, 0, 3, 1, 2, 12);
    tick();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL arm_state: got %0d required 1", state); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (err !== 1'b0 || eval_cnt !== 16'(k) || pass_cnt !== 16'(k) || fail_cnt !== 16'd0) begin
        errors++;
        $display("FAIL assert_pass k=%0d: err=%b ev=%0d ps=%0d fl=%0d, required err=0 ev=%0d ps=%0d fl=0",
                 k, err, eval_cnt, pass_cnt, fail_cnt, k, k);
      end
    end
  endtask

  task automatic test_assert_halt();
    set_ops(6, 0, 3, 7, 2, 10);
    tick();
    checks++;
    if (err !== 1'b1 || fail_cnt !== 16'd1 || fail_mask !== 2'b10 || first_fail_vld !== 1'b1 ||
        first_fail_ch !== 1'b1 || first_fail_cyc !== 16'd3 || state !== 2'd2 || pass_cnt !== 16'd4 || eval_cnt !== 16'd5) begin
      errors++;
      $display("FAIL halt: err=%b fl=%0d mask=%b ffv=%b ffch=%0d ffcyc=%0d st=%0d ps=%0d ev=%0d, required 1 1 10 1 1 3 2 4 5",
               err, fail_cnt, fail_mask, first_fail_vld, first_fail_ch, first_fail_cyc, state, pass_cnt, eval_cnt);
    end
    set_ops(15, 0, 15, 15, 0, 15);
    tick(); tick();
    checks++;
    if (err !== 1'b0 || fail_cnt !== 16'd1 || eval_cnt !== 16'd5 || state !== 2'd2 || fail_mask !== 2'b10) begin
      errors++;
      $display("FAIL halted_freeze: err=%b fl=%0d ev=%0d st=%0d mask=%b, required 0 1 5 2 10",
               err, fail_cnt, eval_cnt, state, fail_mask);
    end
  endtask

  task automatic test_assume();
    en = 0; clr = 1; tick();
    clr = 0; en = 1; mode = 2'd1; tick();
    set_ops(15, 0, 15, 15, 0, 15);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL assume_err k=%0d: got %b required 0", k, err); end
    end
    checks++;
    if (fail_cnt !== 16'd4 || fail_mask !== 2'b11 || first_fail_ch !== 1'b0 || first_fail_cyc !== 16'd0 || state !== 2'd1) begin
      errors++;
      $display("FAIL assume: fl=%0d mask=%b ffch=%0d ffcyc=%0d st=%0d, required 4 11 0 0 1",
               fail_cnt, fail_mask, first_fail_ch, first_fail_cyc, state);
    end
  endtask

  task automatic test_cover();
    en = 0; clr = 1; tick();
    clr = 0; en = 1; mode = 2'd2; tick();
    set_ops(0, 8, 0, 0, 8, 0);
    tick();
    checks++;
    if (pass_cnt !== 16'd2 || state !== 2'd1) begin
      errors++; $display("FAIL cover_1: ps=%0d st=%0d, required 2 1", pass_cnt, state);
    end
    tick();
    checks++;
    if (pass_cnt !== 16'd4 || state !== 2'd3 || fail_cnt !== 16'd0) begin
      errors++; $display("FAIL cover_2: ps=%0d st=%0d fl=%0d, required 4 3 0", pass_cnt, state, fail_cnt);
    end
    tick();
    checks++;
    if (pass_cnt !== 16'd4 || eval_cnt !== 16'd4 || state !== 2'd3) begin
      errors++; $display("FAIL cover_done_freeze: ps=%0d ev=%0d st=%0d, required 4 4 3", pass_cnt, eval_cnt, state);
    end
  endtask

  task automatic test_priority();
    rst = 1; clr = 1; en = 1; mode = 2'd1; tick();
    checks++;
    if (state !== 2'd0 || pass_cnt !== 16'd0 || eval_cnt !== 16'd0) begin
      errors++; $display("FAIL prio_rst: st=%0d ps=%0d ev=%0d, required 0 0 0", state, pass_cnt, eval_cnt);
    end
    rst = 0; tick();
    checks++;
    if ({state, eval_cnt, pass_cnt, fail_cnt, fail_mask, first_fail_vld, err} !== '0) begin
      errors++; $display("FAIL prio_clr: st=%0d ev=%0d ps=%0d, required all 0", state, eval_cnt, pass_cnt);
    end
    clr = 0; mode = 2'd2; tick();
    set_ops(15, 0, 15, 15, 0, 15);
    mode = 2'd0;
    tick();
    checks++;
    if (state !== 2'd1 || eval_cnt !== 16'd2 || fail_cnt !== 16'd0 || err !== 1'b0 || fail_mask !== 2'b00) begin
      errors++;
      $display("FAIL prio_latched_cover: st=%0d ev=%0d fl=%0d err=%b mask=%b, required 1 2 0 0 00",
               state, eval_cnt, fail_cnt, err, fail_mask);
    end
  endtask

  task automatic test_saturation();
    rst = 1; tick();
    rst = 0; en = 1; mode = 2'd0; tick();
    set_ops(6, 0, 0, 6, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (s_pass !== 3'(imin(2*k, 7)) || s_eval !== 3'(imin(2*k, 7))) begin
        errors++;
        $display("FAIL saturation k=%0d: ps=%0d ev=%0d, required %0d", k, s_pass, s_eval, imin(2*k, 7));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 99) < 1);
      clr  = ($urandom_range(0, 99) < 4);
      en   = ($urandom_range(0, 99) < 92);
      mode = 2'($urandom_range(0, 3));
      for (int ch = 0; ch < 2; ch++) begin
        a_flat[4*ch +: 4] = 4'($urandom_range(0, 15));
        b_flat[4*ch +: 4] = 4'($urandom_range(0, 15));
        c_flat[4*ch +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      tick();
      checks++;
      if (state !== 2'(m_state) || eval_cnt !== 16'(m_eval) || pass_cnt !== 16'(m_pass) ||
          fail_cnt !== 16'(m_fail) || fail_mask !== 2'(m_mask) || first_fail_vld !== 1'(m_ffv) ||
          first_fail_ch !== 1'(m_ffch) || first_fail_cyc !== 16'(m_ffcyc) || err !== 1'(m_err)) begin
        errors++;
        $display("FAIL random n=%0d: got st=%0d ev=%0d ps=%0d fl=%0d mask=%b ffv=%b ffch=%0d ffcyc=%0d err=%b required st=%0d ev=%0d ps=%0d fl=%0d mask=%0d ffv=%0d ffch=%0d ffcyc=%0d err=%0d",
                 n, state, eval_cnt, pass_cnt, fail_cnt, fail_mask, first_fail_vld, first_fail_ch, first_fail_cyc, err,
                 m_state, m_eval, m_pass, m_fail, m_mask, m_ffv, m_ffch, m_ffcyc, m_err);
      end
    end
    rst = 0; clr = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_assert_pass();
    test_assert_halt();
    test_assume();
    test_cover();
    test_priority();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
